// File: rtl/param_reservation_station.sv
// param_reservation_station
//   Parameterised out-of-order reservation station. It holds up to DEPTH
//   instructions and wakes pending operands from NCDB common-data-bus ports.
//   Each cycle it offers the oldest ready entry for issue.
//
// Ports
//   clk, rst           single clock; synchronous active-high reset
//   flush              discard every entry at the next edge
//   disp_*             dispatch handshake (valid/ready) and instruction fields
//   cdb_valid/tag/value  NCDB broadcast ports; port p occupies slice p
//   issue_*            issue handshake and the selected entry's fields
//   count              number of occupied entries
module param_reservation_station #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int NCDB  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            disp_valid,
    output logic                            disp_ready,
    input  logic [3:0]                      disp_op,
    input  logic [6:0]                      disp_opcode,
    input  logic [XLEN-1:0]                 disp_vj,
    input  logic [XLEN-1:0]                 disp_vk,
    input  logic [XLEN-1:0]                 disp_imm,
    input  logic [TAG_W-1:0]                disp_qj,
    input  logic [TAG_W-1:0]                disp_qk,
    input  logic [TAG_W-1:0]                disp_rob_tag,
    input  logic [NCDB-1:0]                 cdb_valid,
    input  logic [NCDB*TAG_W-1:0]           cdb_tag,
    input  logic [NCDB*XLEN-1:0]            cdb_value,
    output logic                            issue_valid,
    input  logic                            issue_ready,
    output logic [3:0]                      issue_op,
    output logic [6:0]                      issue_opcode,
    output logic [XLEN-1:0]                 issue_vj,
    output logic [XLEN-1:0]                 issue_vk,
    output logic [XLEN-1:0]                 issue_imm,
    output logic [TAG_W-1:0]                issue_rob_tag,
    output logic [$clog2(DEPTH+1)-1:0]      count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] busy;
    logic [3:0]       op_q     [DEPTH];
    logic [6:0]       opcode_q [DEPTH];
    logic [XLEN-1:0]  vj_q     [DEPTH];
    logic [XLEN-1:0]  vk_q     [DEPTH];
    logic [XLEN-1:0]  imm_q    [DEPTH];
    logic [TAG_W-1:0] qj_q     [DEPTH];
    logic [TAG_W-1:0] qk_q     [DEPTH];
    logic [TAG_W-1:0] tag_q    [DEPTH];
    // older[i][j] set means entry i was dispatched before entry j.
    logic [DEPTH-1:0] older    [DEPTH];
    logic             locked;
    logic [IDX_W-1:0] lock_idx;
    logic [CNT_W-1:0] cnt;

    // Returns {hit, value}. The scan runs from the highest port down, so the
    // lowest-indexed matching port overwrites the rest and wins. Tag 0 never
    // matches.
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [TAG_W-1:0]       tag,
        input logic [NCDB-1:0]        cv,
        input logic [NCDB*TAG_W-1:0]  ct,
        input logic [NCDB*XLEN-1:0]   cd
    );
        logic [XLEN:0] r;
        r = '0;
        for (int p = NCDB - 1; p >= 0; p--) begin
            if (cv[p] && (tag != '0) && (ct[p*TAG_W +: TAG_W] == tag))
                r = {1'b1, cd[p*XLEN +: XLEN]};
        end
        return r;
    endfunction

    logic [XLEN:0]    wake_j [DEPTH];
    logic [XLEN:0]    wake_k [DEPTH];
    logic [XLEN:0]    byp_j, byp_k;
    logic [DEPTH-1:0] rdy, oldest;
    logic [IDX_W-1:0] sel_idx, free_idx;
    logic             sel_hit, do_disp, do_iss;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            wake_j[i] = cdb_lookup(qj_q[i], cdb_valid, cdb_tag, cdb_value);
            wake_k[i] = cdb_lookup(qk_q[i], cdb_valid, cdb_tag, cdb_value);
            rdy[i]    = busy[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
        end
        byp_j = cdb_lookup(disp_qj, cdb_valid, cdb_tag, cdb_value);
        byp_k = cdb_lookup(disp_qk, cdb_valid, cdb_tag, cdb_value);
    end

    // An entry is the oldest ready one when no other ready entry is older.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            oldest[i] = rdy[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (rdy[j] && older[j][i])
                    oldest[i] = 1'b0;
            end
        end
    end

    // A locked entry keeps the issue port until it is accepted.
    always_comb begin
        sel_hit  = 1'b0;
        sel_idx  = '0;
        free_idx = '0;
        if (locked) begin
            sel_hit = 1'b1;
            sel_idx = lock_idx;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (oldest[i]) begin
                    sel_hit = 1'b1;
                    sel_idx = IDX_W'(i);
                end
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i])
                free_idx = IDX_W'(i);
        end
    end

    assign disp_ready    = (cnt < CNT_W'(DEPTH));
    assign do_disp       = disp_valid && disp_ready && !flush;
    assign do_iss        = sel_hit && issue_ready && !flush;
    assign count         = cnt;
    assign issue_valid   = sel_hit;
    assign issue_op      = sel_hit ? op_q[sel_idx]     : '0;
    assign issue_opcode  = sel_hit ? opcode_q[sel_idx] : '0;
    assign issue_vj      = sel_hit ? vj_q[sel_idx]     : '0;
    assign issue_vk      = sel_hit ? vk_q[sel_idx]     : '0;
    assign issue_imm     = sel_hit ? imm_q[sel_idx]    : '0;
    assign issue_rob_tag = sel_hit ? tag_q[sel_idx]    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            locked   <= 1'b0;
            lock_idx <= '0;
            cnt      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]     <= '0;
                opcode_q[i] <= '0;
                vj_q[i]     <= '0;
                vk_q[i]     <= '0;
                imm_q[i]    <= '0;
                qj_q[i]     <= '0;
                qk_q[i]     <= '0;
                tag_q[i]    <= '0;
                older[i]    <= '0;
            end
        end else if (flush) begin
            busy   <= '0;
            locked <= 1'b0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++)
                older[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy[i] && wake_j[i][XLEN]) begin
                    vj_q[i] <= wake_j[i][XLEN-1:0];
                    qj_q[i] <= '0;
                end
                if (busy[i] && wake_k[i][XLEN]) begin
                    vk_q[i] <= wake_k[i][XLEN-1:0];
                    qk_q[i] <= '0;
                end
            end
            if (do_iss)
                busy[sel_idx] <= 1'b0;
            // free_idx is never busy, so it cannot collide with the wakeup
            // writes above or with the slot being issued.
            if (do_disp) begin
                busy[free_idx]     <= 1'b1;
                op_q[free_idx]     <= disp_op;
                opcode_q[free_idx] <= disp_opcode;
                imm_q[free_idx]    <= disp_imm;
                tag_q[free_idx]    <= disp_rob_tag;
                vj_q[free_idx]     <= byp_j[XLEN] ? byp_j[XLEN-1:0] : disp_vj;
                qj_q[free_idx]     <= byp_j[XLEN] ? '0 : disp_qj;
                vk_q[free_idx]     <= byp_k[XLEN] ? byp_k[XLEN-1:0] : disp_vk;
                qk_q[free_idx]     <= byp_k[XLEN] ? '0 : disp_qk;
                // The new entry is younger than every occupied entry. The
                // diagonal bit is rewritten below, where busy[free_idx] is 0.
                older[free_idx] <= '0;
                for (int j = 0; j < DEPTH; j++)
                    older[j][free_idx] <= busy[j];
            end
            if (do_iss) begin
                locked <= 1'b0;
            end else if (sel_hit && !issue_ready) begin
                locked   <= 1'b1;
                lock_idx <= sel_idx;
            end
            case ({do_disp, do_iss})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_param_reservation_station.sv
// Directed self-checking bench for param_reservation_station (DEPTH=8,
// XLEN=32, TAG_W=5, NCDB=2). A vector table covers single-cycle behaviour.
// Hand-written sequences cover fill/full, flush and reset.
module tb_param_reservation_station;
    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int NCDB  = 2;

    logic              clk = 1'b0;
    logic              rst, flush, disp_valid, disp_ready;
    logic [3:0]        disp_op;
    logic [6:0]        disp_opcode;
    logic [XLEN-1:0]   disp_vj, disp_vk, disp_imm;
    logic [TAG_W-1:0]  disp_qj, disp_qk, disp_rob_tag;
    logic [NCDB-1:0]   cdb_valid;
    logic [NCDB*TAG_W-1:0] cdb_tag;
    logic [NCDB*XLEN-1:0]  cdb_value;
    logic              issue_valid, issue_ready;
    logic [3:0]        issue_op;
    logic [6:0]        issue_opcode;
    logic [XLEN-1:0]   issue_vj, issue_vk, issue_imm;
    logic [TAG_W-1:0]  issue_rob_tag;
    logic [3:0]        count;

    param_reservation_station #(
        .DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .NCDB(NCDB)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_op(disp_op), .disp_opcode(disp_opcode),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_imm(disp_imm),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_rob_tag(disp_rob_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_opcode(issue_opcode),
        .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_imm(issue_imm),
        .issue_rob_tag(issue_rob_tag), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        dv;
        logic [4:0]  tag, qj, qk;
        logic [31:0] vj, vk;
        logic [1:0]  cv;
        logic [4:0]  ct0, ct1;
        logic [31:0] cd0, cd1;
        logic        ir;
        logic [3:0]  e_cnt;
        logic        e_iv;
        logic [4:0]  e_tag;
        logic [31:0] e_vj, e_vk;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    function automatic vec_t mk(
        input logic dv, input logic [4:0] tag, qj, qk, input logic [31:0] vj, vk,
        input logic [1:0] cv, input logic [4:0] ct0, input logic [31:0] cd0,
        input logic [4:0] ct1, input logic [31:0] cd1, input logic ir,
        input logic [3:0] e_cnt, input logic e_iv, input logic [4:0] e_tag,
        input logic [31:0] e_vj, e_vk);
        vec_t v;
        v.dv = dv; v.tag = tag; v.qj = qj; v.qk = qk; v.vj = vj; v.vk = vk;
        v.cv = cv; v.ct0 = ct0; v.cd0 = cd0; v.ct1 = ct1; v.cd1 = cd1; v.ir = ir;
        v.e_cnt = e_cnt; v.e_iv = e_iv; v.e_tag = e_tag; v.e_vj = e_vj; v.e_vk = e_vk;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // op and imm are derived from the rob tag at dispatch time, so they can be
    // predicted from the expected tag alone.
    task automatic chk_issue(input string nm, input logic iv, input logic [4:0] tag,
                             input logic [31:0] vj, input logic [31:0] vk);
        chk({nm, "_iv"},  32'(issue_valid),   32'(iv));
        chk({nm, "_tag"}, 32'(issue_rob_tag), iv ? 32'(tag) : 32'h0);
        chk({nm, "_vj"},  issue_vj,           iv ? vj : 32'h0);
        chk({nm, "_vk"},  issue_vk,           iv ? vk : 32'h0);
        chk({nm, "_op"},  32'(issue_op),      iv ? 32'(tag[3:0]) : 32'h0);
        chk({nm, "_imm"}, issue_imm,          iv ? 32'h1000 + 32'(tag) : 32'h0);
    endtask

    task automatic clear_inputs();
        rst = 1'b0; flush = 1'b0; disp_valid = 1'b0;
        disp_op = '0; disp_opcode = '0; disp_vj = '0; disp_vk = '0; disp_imm = '0;
        disp_qj = '0; disp_qk = '0; disp_rob_tag = '0;
        cdb_valid = '0; cdb_tag = '0; cdb_value = '0; issue_ready = 1'b0;
    endtask

    task automatic set_disp(input logic [4:0] tag, qj, qk, input logic [31:0] vj, vk);
        disp_valid = 1'b1; disp_rob_tag = tag; disp_op = tag[3:0];
        disp_opcode = {2'b00, tag}; disp_imm = 32'h1000 + 32'(tag);
        disp_qj = qj; disp_qk = qk; disp_vj = vj; disp_vk = vk;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] exp_order [8];

    initial begin
        //            dv tag qj qk vj      vk      cv    ct0 cd0      ct1 cd1       ir cnt iv tag vj       vk
        tbl[0]  = mk(1, 3,  7, 9, 0,      0,      2'b00, 0, 0,       0, 0,        0, 1, 0, 0,  0,       0);
        tbl[1]  = mk(0, 0,  0, 0, 0,      0,      2'b11, 7, 32'h11,  9, 32'h22,   0, 1, 1, 3,  32'h11,  32'h22);
        tbl[2]  = mk(0, 0,  0, 0, 0,      0,      2'b00, 0, 0,       0, 0,        1, 0, 0, 0,  0,       0);
        tbl[3]  = mk(1, 6,  4, 0, 0,      32'h55, 2'b10, 0, 0,       4, 32'hABCD, 1, 1, 1, 6,  32'hABCD,32'h55);
        tbl[4]  = mk(0, 0,  0, 0, 0,      0,      2'b00, 0, 0,       0, 0,        1, 0, 0, 0,  0,       0);
        tbl[5]  = mk(1, 10, 5, 0, 0,      32'h1,  2'b00, 0, 0,       0, 0,        1, 1, 0, 0,  0,       0);
        tbl[6]  = mk(1, 11, 0, 0, 32'hB0, 32'hB1, 2'b00, 0, 0,       0, 0,        1, 2, 1, 11, 32'hB0,  32'hB1);
        tbl[7]  = mk(0, 0,  0, 0, 0,      0,      2'b11, 5, 32'h77,  5, 32'h99,   1, 1, 1, 10, 32'h77,  32'h1);
        tbl[8]  = mk(0, 0,  0, 0, 0,      0,      2'b00, 0, 0,       0, 0,        1, 0, 0, 0,  0,       0);
        tbl[9]  = mk(1, 12, 8, 0, 0,      32'hA1, 2'b00, 0, 0,       0, 0,        0, 1, 0, 0,  0,       0);
        tbl[10] = mk(1, 13, 0, 0, 32'hC,  32'hD,  2'b00, 0, 0,       0, 0,        0, 2, 1, 13, 32'hC,   32'hD);
        tbl[11] = mk(0, 0,  0, 0, 0,      0,      2'b01, 8, 32'h88,  0, 0,        0, 2, 1, 13, 32'hC,   32'hD);
        tbl[12] = mk(0, 0,  0, 0, 0,      0,      2'b00, 0, 0,       0, 0,        1, 1, 1, 12, 32'h88,  32'hA1);
        tbl[13] = mk(0, 0,  0, 0, 0,      0,      2'b00, 0, 0,       0, 0,        1, 0, 0, 0,  0,       0);
        tbl[14] = mk(1, 14, 0, 0, 32'h1,  32'h0,  2'b00, 0, 0,       0, 0,        0, 1, 1, 14, 32'h1,   32'h0);
        tbl[15] = mk(1, 15, 0, 0, 32'h2,  32'h3,  2'b00, 0, 0,       0, 0,        1, 1, 1, 15, 32'h2,   32'h3);
        tbl[16] = mk(0, 0,  0, 0, 0,      0,      2'b00, 0, 0,       0, 0,        1, 0, 0, 0,  0,       0);

        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_count", 32'(count), 0);
        chk("reset_disp_ready", 32'(disp_ready), 1);
        chk_issue("reset", 1'b0, 0, 0, 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            clear_inputs();
            if (tbl[i].dv)
                set_disp(tbl[i].tag, tbl[i].qj, tbl[i].qk, tbl[i].vj, tbl[i].vk);
            cdb_valid   = tbl[i].cv;
            cdb_tag     = {tbl[i].ct1, tbl[i].ct0};
            cdb_value   = {tbl[i].cd1, tbl[i].cd0};
            issue_ready = tbl[i].ir;
            tick();
            chk($sformatf("v%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk_issue($sformatf("v%0d", i), tbl[i].e_iv, tbl[i].e_tag, tbl[i].e_vj, tbl[i].e_vk);
        end

        // Fill to DEPTH with no issue; the first entry stays at the port.
        for (int k = 1; k <= DEPTH; k++) begin
            @(negedge clk);
            clear_inputs();
            set_disp(5'(k), 0, 0, 32'(k * 16), 32'(k));
            tick();
            chk($sformatf("fill%0d_count", k), 32'(count), 32'(k));
        end
        chk("full_disp_ready", 32'(disp_ready), 0);
        chk_issue("full", 1'b1, 1, 32'h10, 32'h1);
        @(negedge clk);
        clear_inputs();
        tick();
        chk_issue("full_hold", 1'b1, 1, 32'h10, 32'h1);

        // Full with issue and dispatch in the same cycle: the dispatch is refused.
        @(negedge clk);
        clear_inputs();
        set_disp(20, 0, 0, 32'h20, 32'h21);
        issue_ready = 1'b1;
        #1;
        chk("fullsim_ready_before", 32'(disp_ready), 0);
        tick();
        chk("fullsim_count", 32'(count), 7);
        chk("fullsim_disp_ready", 32'(disp_ready), 1);
        chk_issue("fullsim", 1'b1, 2, 32'h20, 32'h2);
        @(negedge clk);
        clear_inputs();
        set_disp(20, 0, 0, 32'h20, 32'h21);
        tick();
        chk("refill_count", 32'(count), 8);
        chk("refill_disp_ready", 32'(disp_ready), 0);

        // Tag 20 occupies slot 0 but is youngest, so it must drain last.
        exp_order[0] = 2;  exp_order[1] = 3; exp_order[2] = 4; exp_order[3] = 5;
        exp_order[4] = 6;  exp_order[5] = 7; exp_order[6] = 8; exp_order[7] = 20;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            clear_inputs();
            issue_ready = 1'b1;
            chk($sformatf("drain%0d_tag", k), 32'(issue_rob_tag), 32'(exp_order[k]));
            tick();
        end
        chk("drain_count", 32'(count), 0);
        chk("drain_iv", 32'(issue_valid), 0);

        // Flush with five entries, a dispatch, an issue and a CDB all pending.
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            clear_inputs();
            set_disp(5'(k), 0, 0, 32'(k), 32'(k));
            tick();
        end
        chk("preflush_count", 32'(count), 5);
        @(negedge clk);
        clear_inputs();
        flush = 1'b1;
        set_disp(9, 0, 0, 32'h9, 32'h9);
        issue_ready = 1'b1;
        cdb_valid = 2'b01; cdb_tag = {5'd0, 5'd3}; cdb_value = {32'h0, 32'h33};
        tick();
        chk("flush_count", 32'(count), 0);
        chk("flush_disp_ready", 32'(disp_ready), 1);
        chk_issue("flush", 1'b0, 0, 0, 0);
        @(negedge clk);
        clear_inputs();
        set_disp(9, 0, 0, 32'h9, 32'hA);
        tick();
        chk("postflush_count", 32'(count), 1);
        chk_issue("postflush", 1'b1, 9, 32'h9, 32'hA);
        @(negedge clk);
        clear_inputs();
        issue_ready = 1'b1;
        tick();

        // Reset asserted with five entries and a pending dispatch and issue.
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            clear_inputs();
            set_disp(5'(k), 0, 0, 32'(k), 32'(k));
            tick();
        end
        chk("prerst_count", 32'(count), 5);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        flush = 1'b1;
        set_disp(9, 0, 0, 32'h9, 32'h9);
        issue_ready = 1'b1;
        tick();
        chk("rst_count", 32'(count), 0);
        chk("rst_disp_ready", 32'(disp_ready), 1);
        chk_issue("rst", 1'b0, 0, 0, 0);
        @(negedge clk);
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
